// File: rtl/multicycle_controller.sv
// Multicycle CPU control unit: instruction-class FSM, condition flags and conditional-execution gating.
// Optional feature macro: CTRL_CMP_EN (adds CMP decode and suppresses its register write-back).
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
  } ctrl_t;

  state_t     state_r;
  state_t     state_next_s;
  ctrl_t      ctrl_r;
  logic [3:0] flags_r;
  logic [1:0] alu_ctrl_s;
  logic [1:0] flag_w_s;
  logic       is_cmp_s;
  logic       cond_ex_s;
  logic       reg_w_s;
  logic       pcs_s;

  // Control word for a state; registered together with the state so the datapath sees clean selects.
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_MEMADR:   c.alu_src_b = 2'b01;
      S_MEMREAD:  c.adr_src   = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      S_EXECUTER: c.alu_op = 1'b1;
      S_EXECUTEI: begin
        c.alu_src_b = 2'b01;
        c.alu_op    = 1'b1;
      end
      S_ALUWB:    c.reg_w = 1'b1;
      S_BRANCH: begin
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.branch     = 1'b1;
      end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection from the current state and instruction class.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH:  state_next_s = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_next_s = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_next_s = S_MEMADR;
          2'b10:   state_next_s = S_BRANCH;
          default: state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next_s = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next_s = S_MEMWB;
      S_EXECUTER: state_next_s = S_ALUWB;
      S_EXECUTEI: state_next_s = S_ALUWB;
      default:    state_next_s = S_FETCH;
    endcase
  end

  // State register and its registered control word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
      ctrl_r  <= decode_state(S_FETCH);
    end else begin
      state_r <= state_next_s;
      ctrl_r  <= decode_state(state_next_s);
    end
  end

  // ALU function decode and flag-write qualifiers, active only in execute states.
  always_comb begin
    alu_ctrl_s = 2'b00;
    flag_w_s   = 2'b00;
    is_cmp_s   = 1'b0;
`ifdef CTRL_CMP_EN
    is_cmp_s   = (Funct[4:1] == 4'b1010);
`else
    is_cmp_s   = 1'b0;
`endif
    if (ctrl_r.alu_op) begin
      case (Funct[4:1])
        4'b0100: alu_ctrl_s = 2'b00;
        4'b0010: alu_ctrl_s = 2'b01;
        4'b0000: alu_ctrl_s = 2'b10;
        4'b1100: alu_ctrl_s = 2'b11;
`ifdef CTRL_CMP_EN
        4'b1010: alu_ctrl_s = 2'b01;
`endif
        default: alu_ctrl_s = 2'b00;
      endcase
      flag_w_s[1] = Funct[0];
      flag_w_s[0] = Funct[0] & ((alu_ctrl_s == 2'b00) | (alu_ctrl_s == 2'b01));
    end else begin
      alu_ctrl_s = 2'b00;
      flag_w_s   = 2'b00;
    end
  end

  // Condition evaluation against the stored flags {N,Z,C,V}.
  always_comb begin
    cond_ex_s = 1'b0;
    case (Cond)
      4'b0000: cond_ex_s = flags_r[2];
      4'b0001: cond_ex_s = ~flags_r[2];
      4'b0010: cond_ex_s = flags_r[1];
      4'b0011: cond_ex_s = ~flags_r[1];
      4'b0100: cond_ex_s = flags_r[3];
      4'b0101: cond_ex_s = ~flags_r[3];
      4'b0110: cond_ex_s = flags_r[0];
      4'b0111: cond_ex_s = ~flags_r[0];
      4'b1000: cond_ex_s = flags_r[1] & ~flags_r[2];
      4'b1001: cond_ex_s = ~flags_r[1] | flags_r[2];
      4'b1010: cond_ex_s = (flags_r[3] == flags_r[0]);
      4'b1011: cond_ex_s = (flags_r[3] != flags_r[0]);
      4'b1100: cond_ex_s = ~flags_r[2] & (flags_r[3] == flags_r[0]);
      4'b1101: cond_ex_s = flags_r[2] | (flags_r[3] != flags_r[0]);
      4'b1110: cond_ex_s = 1'b1;
      default: cond_ex_s = 1'b0;
    endcase
  end

  // Flag register: N/Z and C/V halves load independently, only when the condition passes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_r <= 4'b0000;
    end else begin
      if (flag_w_s[1] & cond_ex_s) begin
        flags_r[3:2] <= ALUFlags[3:2];
      end
      if (flag_w_s[0] & cond_ex_s) begin
        flags_r[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // CMP reaches ALUWB only to keep the cycle count; its result is never written back.
  assign reg_w_s = ctrl_r.reg_w & ~(is_cmp_s & (state_r == S_ALUWB));
  assign pcs_s   = ctrl_r.branch | (reg_w_s & (Rd == 4'b1111));

  // Write enables are forced low while reset is held, whatever the state.
  assign PCWrite    = reset_n & (ctrl_r.next_pc | (pcs_s & cond_ex_s));
  assign RegWrite   = reset_n & reg_w_s & cond_ex_s;
  assign MemWrite   = reset_n & ctrl_r.mem_w & cond_ex_s;
  assign IRWrite    = reset_n & ctrl_r.ir_write;
  assign AdrSrc     = ctrl_r.adr_src;
  assign ResultSrc  = ctrl_r.result_src;
  assign ALUSrcA    = ctrl_r.alu_src_a;
  assign ALUSrcB    = ctrl_r.alu_src_b;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};
  assign ALUControl = alu_ctrl_s;
  assign Flags      = flags_r;
  assign State      = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus randomized
// instruction streams compared against a path-level reference model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0] Flags, State;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       pcw;
    logic       memw;
    logic       regw;
    logic       irw;
    logic       adrsrc;
    logic [1:0] ressrc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [1:0] aluctl;
    logic [3:0] flags;
    logic [3:0] state;
  } out_t;

  out_t       obs  [8];
  out_t       expv [8];
  int         ncyc;
  logic [3:0] mflags;

`ifdef CTRL_CMP_EN
  localparam logic [1:0] CMP_ALUCTL = 2'b01;
  localparam logic       CMP_REGW   = 1'b0;
`else
  localparam logic [1:0] CMP_ALUCTL = 2'b00;
  localparam logic       CMP_REGW   = 1'b1;
`endif

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags), .State(State)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t o;
    o.pcw = PCWrite; o.memw = MemWrite; o.regw = RegWrite; o.irw = IRWrite;
    o.adrsrc = AdrSrc; o.ressrc = ResultSrc; o.srca = ALUSrcA; o.srcb = ALUSrcB;
    o.immsrc = ImmSrc; o.regsrc = RegSrc; o.aluctl = ALUControl; o.flags = Flags;
    o.state = State;
    return o;
  endfunction

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_fn(input logic [5:0] f);
    logic [3:0] k;
    k = f[4:1];
    if (k == 4'b0010) return 2'b01;
    if (k == 4'b0000) return 2'b10;
    if (k == 4'b1100) return 2'b11;
`ifdef CTRL_CMP_EN
    if (k == 4'b1010) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic bit is_cmp(input logic [5:0] f);
`ifdef CTRL_CMP_EN
    return f[4:1] == 4'b1010;
`else
    return 1'b0;
`endif
  endfunction

  // Runs one instruction from FETCH; records DUT outputs and model expectations per cycle.
  task automatic exec_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] r, input logic [3:0] af, input bit rnd);
    int path[$];
    Cond = c; Op = o; Funct = f; Rd = r;
    path = {0, 1};
    if (o == 2'b00) begin
      path.push_back(f[5] ? 7 : 6);
      path.push_back(8);
    end else if (o == 2'b01) begin
      path.push_back(2);
      if (f[0]) begin path.push_back(3); path.push_back(4); end
      else path.push_back(5);
    end else if (o == 2'b10) begin
      path.push_back(9);
    end
    ncyc = path.size();
    for (int k = 0; k < ncyc; k++) begin
      int s;
      bit aluop, regw, cx;
      logic [1:0] ctl;
      out_t e;
      s = path[k];
      ALUFlags = rnd ? 4'($urandom) : af;
      aluop = (s == 6) || (s == 7);
      ctl = aluop ? alu_fn(f) : 2'b00;
      regw = (s == 4) || (s == 8 && !is_cmp(f));
      cx = cond_holds(c, mflags);
      e.pcw = (s == 0) || (((s == 9) || (regw && r == 4'hF)) && cx);
      e.regw = regw && cx;
      e.memw = (s == 5) && cx;
      e.irw = (s == 0);
      e.adrsrc = (s == 3) || (s == 5);
      e.ressrc = (s <= 1 || s == 9) ? 2'b10 : (s == 4) ? 2'b01 : 2'b00;
      e.srca = (s <= 1);
      e.srcb = (s <= 1) ? 2'b10 : (s == 2 || s == 7 || s == 9) ? 2'b01 : 2'b00;
      e.immsrc = o;
      e.regsrc = {(o == 2'b01) && !f[0], o == 2'b10};
      e.aluctl = ctl;
      e.flags = mflags;
      e.state = 4'(s);
      expv[k] = e;
      @(negedge clk);
      obs[k] = sample();
      @(posedge clk);
      if (aluop && cx && f[0]) begin
        mflags[3:2] = ALUFlags[3:2];
        if (ctl <= 2'b01) mflags[1:0] = ALUFlags[1:0];
      end
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; Cond = 4'hE; Op = 2'b11; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    mflags = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", State); end
    checks++; if (Flags !== 4'd0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", Flags); end
    checks++; if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
      errors++; $display("FAIL reset_enables: got %b expected 0000", {PCWrite, MemWrite, RegWrite, IRWrite}); end
    checks++; if ({ALUSrcA, ALUSrcB, ResultSrc} !== 5'b11010) begin
      errors++; $display("FAIL reset_muxes: got %b expected 11010", {ALUSrcA, ALUSrcB, ResultSrc}); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if ({State, IRWrite, PCWrite} !== {4'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL cycle0: got state=%0d irw=%b pcw=%b expected 0 1 1", State, IRWrite, PCWrite); end
    @(posedge clk); #1;
    checks++; if (State !== 4'd1) begin errors++; $display("FAIL cycle1_state: got %0d expected 1", State); end
    checks++; if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
      errors++; $display("FAIL cycle1_enables: got %b expected 0000", {PCWrite, MemWrite, RegWrite, IRWrite}); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int sq[4];
    sq = '{0, 1, 6, 8};
    exec_instr(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0100, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (obs[k].state !== 4'(sq[k])) begin errors++; $display("FAIL add_state[%0d]: got %0d expected %0d", k, obs[k].state, sq[k]); end
      checks++; if (obs[k].regw !== (k == 3)) begin errors++; $display("FAIL add_regw[%0d]: got %b expected %b", k, obs[k].regw, k == 3); end
    end
    checks++; if (obs[2].aluctl !== 2'b00) begin errors++; $display("FAIL add_aluctl: got %b expected 00", obs[2].aluctl); end
    checks++; if (obs[3].flags !== 4'b0100) begin errors++; $display("FAIL add_flags: got %b expected 0100", obs[3].flags); end
  endtask

  task automatic test_ldr_str();
    int lq[5];
    lq = '{0, 1, 2, 3, 4};
    exec_instr(4'hE, 2'b01, 6'b000001, 4'd2, 4'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checks++; if (obs[k].state !== 4'(lq[k])) begin errors++; $display("FAIL ldr_state[%0d]: got %0d expected %0d", k, obs[k].state, lq[k]); end
    end
    checks++; if (obs[3].adrsrc !== 1'b1) begin errors++; $display("FAIL ldr_adrsrc: got %b expected 1", obs[3].adrsrc); end
    checks++; if ({obs[4].ressrc, obs[4].regw} !== 3'b011) begin
      errors++; $display("FAIL ldr_wb: got %b expected 011", {obs[4].ressrc, obs[4].regw}); end
    exec_instr(4'hE, 2'b01, 6'b000000, 4'd2, 4'd0, 1'b0);
    checks++; if (ncyc != 4 || obs[2].state !== 4'd2 || obs[3].state !== 4'd5) begin
      errors++; $display("FAIL str_path: got len=%0d s2=%0d s3=%0d expected 4 2 5", ncyc, obs[2].state, obs[3].state); end
    checks++; if (obs[3].memw !== 1'b1) begin errors++; $display("FAIL str_memw: got %b expected 1", obs[3].memw); end
  endtask

  task automatic test_branch();
    exec_instr(4'h0, 2'b10, 6'd0, 4'd0, 4'd0, 1'b0);
    checks++; if ({obs[2].state, obs[2].pcw} !== {4'd9, 1'b1}) begin
      errors++; $display("FAIL beq_taken: got state=%0d pcw=%b expected 9 1", obs[2].state, obs[2].pcw); end
    exec_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0000, 1'b0);
    exec_instr(4'h0, 2'b10, 6'd0, 4'd0, 4'd0, 1'b0);
    checks++; if ({obs[2].state, obs[2].pcw} !== {4'd9, 1'b0}) begin
      errors++; $display("FAIL beq_not_taken: got state=%0d pcw=%b expected 9 0", obs[2].state, obs[2].pcw); end
    exec_instr(4'hE, 2'b11, 6'd0, 4'd0, 4'd0, 1'b0);
    checks++; if ({obs[0].state, obs[1].state} !== {4'd0, 4'd1}) begin
      errors++; $display("FAIL after_branch: got %0d %0d expected 0 1", obs[0].state, obs[1].state); end
  endtask

  task automatic test_pc_dest();
    exec_instr(4'hE, 2'b00, 6'b101000, 4'hF, 4'd0, 1'b0);
    checks++; if ({obs[2].state, obs[3].state, obs[3].pcw, obs[3].regw} !== {4'd7, 4'd8, 1'b1, 1'b1}) begin
      errors++; $display("FAIL pc_dest: got s=%0d,%0d pcw=%b regw=%b expected 7,8 1 1",
                         obs[2].state, obs[3].state, obs[3].pcw, obs[3].regw); end
  endtask

  task automatic test_cmp();
    exec_instr(4'hE, 2'b00, 6'b000101, 4'd3, 4'b0010, 1'b0);
    checks++; if ({obs[2].aluctl, obs[3].flags} !== {2'b01, 4'b0010}) begin
      errors++; $display("FAIL subs: got aluctl=%b flags=%b expected 01 0010", obs[2].aluctl, obs[3].flags); end
    exec_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0110, 1'b0);
    checks++; if (obs[2].aluctl !== CMP_ALUCTL) begin
      errors++; $display("FAIL cmp_aluctl: got %b expected %b", obs[2].aluctl, CMP_ALUCTL); end
    checks++; if (obs[3].regw !== CMP_REGW) begin
      errors++; $display("FAIL cmp_regw: got %b expected %b", obs[3].regw, CMP_REGW); end
    checks++; if (obs[3].flags !== 4'b0110) begin
      errors++; $display("FAIL cmp_flags: got %b expected 0110", obs[3].flags); end
  endtask

  task automatic test_reset_midflight();
    Cond = 4'hE; Op = 2'b01; Funct = 6'd0; Rd = 4'd4; ALUFlags = 4'd0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if ({State, MemWrite} !== {4'd5, 1'b1}) begin
      errors++; $display("FAIL midflight_pre: got state=%0d memw=%b expected 5 1", State, MemWrite); end
    reset_n = 1'b0;
    #1;
    mflags = 4'd0;
    checks++; if ({State, MemWrite, Flags} !== {4'd0, 1'b0, 4'd0}) begin
      errors++; $display("FAIL midflight_reset: got state=%0d memw=%b flags=%b expected 0 0 0000", State, MemWrite, Flags); end
    Op = 2'b11;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL midflight_resume: got %0d expected 0", State); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [3:0] c, r;
      c = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
      r = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      exec_instr(c, 2'($urandom), 6'($urandom), r, 4'd0, 1'b1);
      for (int k = 0; k < ncyc; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin
          errors++;
          $display("FAIL random[%0d.%0d]: got %h expected %h (cond=%h op=%b funct=%b rd=%h)",
                   n, k, obs[k], expv[k], Cond, Op, Funct, Rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr_str();
    test_branch();
    test_pc_dest();
    test_cmp();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control unit for the multicycle build of the CPU. Holds the instruction-class state machine, the condition-flag register and the conditional-execution logic. Each cycle it drives the datapath write enables and mux selects, so one shared ALU and one unified memory serve fetch, address generation, execute and write-back. It sits between the instruction register fields and the datapath, in the same slot the single-cycle decoder fills.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous reset, active low; one clock, asynchronous active-low reset
- Cond  in  4  instruction bits [31:28], from the instruction register
- Op  in  2  instruction bits [27:26]
- Funct  in  6  instruction bits [25:20]
- Rd  in  4  instruction bits [15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  out  1  PC register enable
- MemWrite  out  1  memory write enable
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALU result register
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALU result
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=register B, 01=extended immediate, 10=constant 4
- ImmSrc  out  2  equal to Op at all times
- RegSrc  out  2  [0]=Op==10, [1]=Op==01 & !Funct[0]
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- Flags  out  4  current flag register {N,Z,C,V}
- State  out  4  current state encoding, for debug

## Operation
- States, with encoding and next state:
  - FETCH 0 → DECODE
  - DECODE 1 → MEMADR if Op=01; EXECUTEI if Op=00 and Funct[5]; EXECUTER if Op=00 and !Funct[5]; BRANCH if Op=10; FETCH if Op=11
  - MEMADR 2 → MEMREAD if Funct[0], else MEMWRITE
  - MEMREAD 3 → MEMWB
  - MEMWB 4 → FETCH
  - MEMWRITE 5 → FETCH
  - EXECUTER 6 → ALUWB
  - EXECUTEI 7 → ALUWB
  - ALUWB 8 → FETCH
  - BRANCH 9 → FETCH
  - Codes 10–15 → FETCH
- Per-state outputs (any field not listed is 0):
  - FETCH: IRWrite, NextPC, ALUSrcA=1, ALUSrcB=10, ResultSrc=10
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10
  - MEMADR: ALUSrcB=01
  - MEMREAD: AdrSrc=1
  - MEMWB: ResultSrc=01, RegW
  - MEMWRITE: AdrSrc=1, MemW
  - EXECUTER: ALUOp
  - EXECUTEI: ALUSrcB=01, ALUOp
  - ALUWB: RegW
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch
- ALU decode applies only when ALUOp=1; otherwise ALUControl=00 and FlagW=00.
  - Funct[4:1] mapping: 0100→00, 0010→01, 0000→10, 1100→11; any other value →00.
  - FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ALUControl is 00 or 01).
- Condition logic (CondEx, combinational from Cond and the Flags register):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL (1110) 1; 1111 → 0
- Output gating:
  - PCS = Branch | (RegW & Rd==1111)
  - PCWrite = NextPC | (PCS & CondEx)
  - RegWrite = RegW & CondEx
  - MemWrite = MemW & CondEx
- Flags register: N,Z load ALUFlags[3:2] when FlagW[1]&CondEx; C,V load ALUFlags[1:0] when FlagW[0]&CondEx.

## Timing
- Reset, while reset_n=0: State=FETCH and Flags=0000. PCWrite=0, MemWrite=0, RegWrite=0, IRWrite=0. Mux selects hold their FETCH values.
- After reset release: first rising edge completes FETCH.
- Cycles per instruction: LDR 5, STR 4, data-processing 4, B 3, Op=11 2 (NOP).
- Flags update on the edge that ends EXECUTER/EXECUTEI, using ALUFlags of that cycle. They are first visible in ALUWB, which matters for PC-destination writes.
- A failed condition still walks the full state path, with all writes except NextPC suppressed.
- reset_n asserted in any state returns State to FETCH immediately. Any in-flight writes are abandoned.

## Configuration
- CTRL_CMP_EN defined:
  - Funct[4:1]=1010 (CMP) decodes to ALUControl=01 with flags per S.
  - The ALUWB cycle for CMP forces RegW=0 (no register write, no PCS).
- CTRL_CMP_EN undefined:
  - 1010 decodes as an unrecognised function: ALUControl=00, FlagW per the rules above.
  - RegWrite is asserted in ALUWB.

## Test plan
- Release reset: cycle 0 State=0, IRWrite=1, PCWrite=1. Cycle 1 State=1, all write enables 0.
- ADD r1,r2,r3 with S (Cond=1110, Op=00, Funct=001001), ALUFlags=0100:
  - States 0,1,6,8; ALUControl=00 in state 6.
  - Flags=0100 in state 8; RegWrite=1 in state 8 only.
- LDR then STR (Op=01, Funct[0]=1 then 0):
  - LDR: states 0,1,2,3,4 with AdrSrc=1 in state 3 and ResultSrc=01, RegWrite=1 in state 4.
  - STR: states 0,1,2,5 with MemWrite=1 in state 5.
- BEQ (Cond=0000, Op=10):
  - Z=1: PCWrite=1 in state 9.
  - Z=0: PCWrite=0 in state 9; next state 0.
- Data-processing write to Rd=1111: PCWrite=1 and RegWrite=1 in ALUWB.
- SUBS then CMP (Funct=010101), with and without CTRL_CMP_EN:
  - Macro defined: ALUControl=01 and RegWrite=0 in ALUWB.
  - Macro undefined: ALUControl=00 and RegWrite=1 in ALUWB.
